sd_cmd_seq: RTL and testbench
=============================

# sd_cmd_seq

Parametrised SDRAM command sequencer that drives one SDRAM rank's command, bank, address and byte-mask pins from a single-request valid/ready port. It is the successor to the fixed-width single-channel SDRAM pin block. Bank, row, column and mask widths are generic, and it adds a power-up init sequence, periodic auto-refresh, a CAS-latency read strobe and closed-page (auto-precharge) access. It sits between the memory arbiter and the SDRAM pad ring.

## Interface
- ROW_W, 12: row/address pin width (sd_adrs)
- COL_W, 10: column width; must be ≤10 and < ROW_W
- BA_W, 2: bank address width
- DQM_W, 8: byte-mask width
- CL, 2: CAS latency in cycles (2 or 3)
- T_RCD, 2: ACT-to-RD/WR cycles (≥1)
- T_RP, 2: precharge period in cycles (≥1)
- T_RFC, 7: refresh cycle time (≥1)
- T_DONE, 4: cycles after RD/WR command before returning to IDLE (covers tWR+tRP)
- REF_INT, 780: cycles between refresh requests
- INIT_CYC, 20000: power-up NOP wait
- MODE_REG, 12'h022: value driven on sd_adrs for MRS (zero-extended to ROW_W)
- sd_clk  in  1  clock; all logic rising-edge
- sd_rst_  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_bank  in  BA_W  bank
- req_row  in  ROW_W  row
- req_col  in  COL_W  column
- req_dqm_l  in  DQM_W  active-low byte mask for the access
- sd_cs_, sd_ras_, sd_cas_, sd_we_  out  1 each  SDRAM command pins, registered
- sd_ba  out  BA_W  registered
- sd_adrs  out  ROW_W  registered
- sd_dqm_l  out  DQM_W  registered
- rd_valid  out  1  pulses when read data is on the bus
- init_done  out  1  high once init completes; low until then

## Operation
- Command encodings (cs_,ras_,cas_,we_): DESEL 1111, NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000.
- Reset values: command DESEL, sd_ba=0, sd_adrs=0, sd_dqm_l=all ones, req_ready=0, rd_valid=0, init_done=0. FSM goes to INIT_WAIT. Refresh counter and CL pipe are cleared.
- Init: INIT_WAIT (INIT_CYC NOPs) → PRE with adrs[10]=1 (all banks) → T_RP NOPs → REF → T_RFC NOPs → REF → T_RFC NOPs → MRS (adrs=MODE_REG, ba=0) → 2 NOPs → IDLE with init_done=1.
- IDLE: command NOP, dqm all ones.
  - req_ready = (state==IDLE) & !ref_pend. It is combinational from registered state only and never from req_valid.
  - If ref_pend is set, IDLE goes to REF, then T_RFC NOPs, then IDLE. ref_pend clears when the REF command issues.
  - Otherwise, on acceptance, bank/row/col/dqm/write are captured and the FSM goes to ACT.
- Access sequence: ACT (ba=req_bank, adrs=req_row) → T_RCD−1 NOPs → RD/WR (ba, adrs[COL_W-1:0]=col, adrs[10]=1 for auto-precharge, other bits 0, dqm=captured mask) → T_DONE NOPs with dqm all ones → IDLE.
- Refresh timer:
  - Counts from 0 starting when init_done rises. It sets ref_pend at REF_INT−1 and wraps to 0.
  - An expiry while ref_pend is already set is dropped; there is no accumulation.
  - An access in flight is never aborted. The refresh waits until the FSM is back in IDLE.
- rd_valid: a CL-deep shift pipe loaded with 1 on RD issue. It pulses 1 cycle, exactly CL cycles after the RD command appears on the pins.
- Reset asserted mid-operation: all state returns to reset values at once, and the full init sequence reruns.

## Timing
- All outputs are registered. A request accepted at edge N puts ACT on the pins in cycle N+1.
- RD/WR appears T_RCD cycles after ACT.
- req_ready returns T_DONE+1 cycles after RD/WR.
- Back-to-back requests: minimum spacing is 1+T_RCD+T_DONE+1 cycles.
- Refresh has priority over a request presented in the same IDLE cycle.

## Test plan
- Reset values and init, with INIT_CYC=10, T_RP=2, T_RFC=4:
  - Hold sd_rst_=0 → pins show DESEL and dqm=FF.
  - Release → 10 NOPs, PRE with adrs[10]=1, 2 NOPs, REF, 4 NOPs, REF, 4 NOPs, MRS with adrs=022, 2 NOPs.
  - init_done rises on cycle 27 after release.
- Write, with T_RCD=2: request bank 1, row 0x3A5, col 0x17, dqm_l 0xF0 → ACT ba=1 adrs=3A5 on the next cycle.
  - WR two cycles later with adrs=0x417 and dqm=F0.
  - req_ready low for T_DONE+1 cycles after the WR.
- Read, with CL=2 then CL=3: RD at cycle K → rd_valid high only at K+2 (K+3 for CL=3), exactly one pulse.
- Refresh collision, with REF_INT=50: req_valid held at the cycle ref_pend sets → REF issues first, then T_RFC NOPs, then the request is accepted.
  - Also: during an access that spans the expiry, REF issues right after the access returns to IDLE.
- Reset mid-access: assert sd_rst_ between ACT and RD → outputs go DESEL/dqm FF asynchronously, no RD is issued, and the init sequence repeats after release.
- Width sweep: ROW_W=13, BA_W=3, DQM_W=4, COL_W=9 → bank 5, row 0x1ABC and col 0x1FF drive correctly. A10 is the only high bit above the column on RD/WR.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// SDRAM command sequencer: power-up init, auto-refresh and closed-page single accesses
// driven from a valid/ready request port onto registered SDRAM command/address pins.
module sd_cmd_seq #(
  parameter int          ROW_W    = 12,
  parameter int          COL_W    = 10,
  parameter int          BA_W     = 2,
  parameter int          DQM_W    = 8,
  parameter int          CL       = 2,
  parameter int          T_RCD    = 2,
  parameter int          T_RP     = 2,
  parameter int          T_RFC    = 7,
  parameter int          T_DONE   = 4,
  parameter int          REF_INT  = 780,
  parameter int          INIT_CYC = 20000,
  parameter logic [11:0] MODE_REG = 12'h022
) (
  input  logic             sd_clk,
  input  logic             sd_rst_,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BA_W-1:0]  req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic [DQM_W-1:0] req_dqm_l,
  output logic             sd_cs_,
  output logic             sd_ras_,
  output logic             sd_cas_,
  output logic             sd_we_,
  output logic [BA_W-1:0]  sd_ba,
  output logic [ROW_W-1:0] sd_adrs,
  output logic [DQM_W-1:0] sd_dqm_l,
  output logic             rd_valid,
  output logic             init_done
);

  localparam int CNT_W = $clog2(INIT_CYC + T_RFC + T_RP + T_RCD + T_DONE + 2);
  localparam int REF_W = $clog2(REF_INT + 1);

  localparam logic [CNT_W-1:0] C_INIT = CNT_W'(INIT_CYC);
  localparam logic [CNT_W-1:0] C_RP   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] C_RFC  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] C_RCD  = (T_RCD > 1) ? CNT_W'(T_RCD - 2) : '0;
  localparam logic [CNT_W-1:0] C_DONE = CNT_W'(T_DONE - 1);
  localparam logic [CNT_W-1:0] C_MRD  = CNT_W'(1);
  localparam logic [REF_W-1:0] C_REF  = REF_W'(REF_INT - 1);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_TRP, S_INIT_REF1,
    S_INIT_RFC1, S_INIT_REF2, S_INIT_RFC2, S_INIT_MRS,
    S_INIT_MRD, S_IDLE, S_REF, S_RFC,
    S_ACT, S_RCD, S_RW, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               ref_pend_q, ref_pend_d;
  logic               init_done_q, init_done_d;
  logic [BA_W-1:0]    bank_q, bank_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [DQM_W-1:0]   mask_q, mask_d;
  logic               write_q, write_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [BA_W-1:0]    ba_q, ba_d;
  logic [ROW_W-1:0]   adrs_q, adrs_d;
  logic [DQM_W-1:0]   dqm_q, dqm_d;
  logic [CL-1:0]      rd_pipe_q, rd_pipe_d;
  logic               ref_issue;
  logic               ref_expire;
  logic               cnt_busy;

  assign cnt_busy = (cnt_q != '0);

  // Each timed state holds for cnt+1 cycles; one-cycle command states leave cnt at 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    bank_d      = bank_q;
    col_d       = col_q;
    mask_d      = mask_q;
    write_d     = write_q;
    ref_issue   = 1'b0;
    case (state_q)
      S_INIT_WAIT: if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_INIT_PRE;
      S_INIT_PRE:  begin state_d = S_INIT_TRP;  cnt_d = C_RP;  end
      S_INIT_TRP:  if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_INIT_REF1;
      S_INIT_REF1: begin state_d = S_INIT_RFC1; cnt_d = C_RFC; end
      S_INIT_RFC1: if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_INIT_REF2;
      S_INIT_REF2: begin state_d = S_INIT_RFC2; cnt_d = C_RFC; end
      S_INIT_RFC2: if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_INIT_MRS;
      S_INIT_MRS:  begin state_d = S_INIT_MRD;  cnt_d = C_MRD; end
      S_INIT_MRD: begin
        if (cnt_busy) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        // Pending refresh wins over a request offered in the same cycle.
        if (ref_pend_q) begin
          state_d   = S_REF;
          ref_issue = 1'b1;
        end else if (req_valid) begin
          state_d = S_ACT;
          bank_d  = req_bank;
          col_d   = req_col;
          mask_d  = req_dqm_l;
          write_d = req_write;
        end
      end
      S_REF:  begin state_d = S_RFC; cnt_d = C_RFC; end
      S_RFC:  if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_IDLE;
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_RCD;
          cnt_d   = C_RCD;
        end else begin
          state_d = S_RW;
        end
      end
      S_RCD:  if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_RW;
      S_RW:   begin state_d = S_DONE; cnt_d = C_DONE; end
      S_DONE: if (cnt_busy) cnt_d = cnt_q - CNT_W'(1); else state_d = S_IDLE;
      default: state_d = S_INIT_WAIT;
    endcase
  end

  // Pins are registered from the upcoming state so each command shows for that state's cycle.
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    adrs_d = '0;
    dqm_d  = '1;
    case (state_d)
      S_INIT_PRE: begin
        cmd_d      = CMD_PRE;
        adrs_d[10] = 1'b1;
      end
      S_INIT_REF1, S_INIT_REF2, S_REF: cmd_d = CMD_REF;
      S_INIT_MRS: begin
        cmd_d  = CMD_MRS;
        adrs_d = ROW_W'(MODE_REG);
      end
      S_ACT: begin
        cmd_d  = CMD_ACT;
        ba_d   = req_bank;
        adrs_d = req_row;
      end
      S_RW: begin
        cmd_d              = write_q ? CMD_WR : CMD_RD;
        ba_d               = bank_q;
        adrs_d[COL_W-1:0]  = col_q;
        adrs_d[10]         = 1'b1;
        dqm_d              = mask_q;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_expire = 1'b0;
    if (init_done_q) begin
      if (ref_cnt_q == C_REF) begin
        ref_cnt_d  = '0;
        ref_expire = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
      end
    end
    ref_pend_d = ref_pend_q;
    if (ref_issue)       ref_pend_d = 1'b0;
    else if (ref_expire) ref_pend_d = 1'b1;
  end

  // Stage 0 fills the cycle after RD is on the pins, so the last stage lands at RD+CL.
  assign rd_pipe_d[0] = (state_q == S_RW) && !write_q;
  for (genvar gi = 1; gi < CL; gi++) begin : g_rd_pipe
    assign rd_pipe_d[gi] = rd_pipe_q[gi-1];
  end

  always_ff @(posedge sd_clk or negedge sd_rst_) begin
    if (!sd_rst_) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= C_INIT;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      init_done_q <= 1'b0;
      bank_q      <= '0;
      col_q       <= '0;
      mask_q      <= '1;
      write_q     <= 1'b0;
      cmd_q       <= CMD_DESEL;
      ba_q        <= '0;
      adrs_q      <= '0;
      dqm_q       <= '1;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      init_done_q <= init_done_d;
      bank_q      <= bank_d;
      col_q       <= col_d;
      mask_q      <= mask_d;
      write_q     <= write_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      adrs_q      <= adrs_d;
      dqm_q       <= dqm_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !ref_pend_q;
  assign {sd_cs_, sd_ras_, sd_cas_, sd_we_} = cmd_q;
  assign sd_ba     = ba_q;
  assign sd_adrs   = adrs_q;
  assign sd_dqm_l  = dqm_q;
  assign rd_valid  = rd_pipe_q[CL-1];
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Directed bench for sd_cmd_seq: one 12-bit-row instance with fast refresh and CL=2,
// one 13-bit-row / 3-bit-bank / 4-bit-mask instance with CL=3.
module tb_sd_cmd_seq;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_c = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [12:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [7:0]  req_dqm = '0;
  int          sel = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_cs, a_ras, a_cas, a_we, a_rdv, a_init;
  logic [1:0]  a_ba;
  logic [11:0] a_adrs;
  logic [7:0]  a_dqm;
  logic        c_valid, c_ready, c_cs, c_ras, c_cas, c_we, c_rdv, c_init;
  logic [2:0]  c_ba;
  logic [12:0] c_adrs;
  logic [3:0]  c_dqm;

  assign a_valid = req_valid && (sel == 0);
  assign c_valid = req_valid && (sel == 1);

  sd_cmd_seq #(
    .ROW_W(12), .COL_W(10), .BA_W(2), .DQM_W(8), .CL(2), .T_RCD(2), .T_RP(2),
    .T_RFC(4), .T_DONE(4), .REF_INT(50), .INIT_CYC(10), .MODE_REG(12'h022)
  ) u_a (
    .sd_clk(clk), .sd_rst_(rst_a), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(req_write), .req_bank(req_bank[1:0]), .req_row(req_row[11:0]),
    .req_col(req_col), .req_dqm_l(req_dqm), .sd_cs_(a_cs), .sd_ras_(a_ras),
    .sd_cas_(a_cas), .sd_we_(a_we), .sd_ba(a_ba), .sd_adrs(a_adrs),
    .sd_dqm_l(a_dqm), .rd_valid(a_rdv), .init_done(a_init)
  );

  sd_cmd_seq #(
    .ROW_W(13), .COL_W(9), .BA_W(3), .DQM_W(4), .CL(3), .T_RCD(2), .T_RP(2),
    .T_RFC(4), .T_DONE(4), .REF_INT(1000), .INIT_CYC(10), .MODE_REG(12'h022)
  ) u_c (
    .sd_clk(clk), .sd_rst_(rst_c), .req_valid(c_valid), .req_ready(c_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
    .req_col(req_col[8:0]), .req_dqm_l(req_dqm[3:0]), .sd_cs_(c_cs), .sd_ras_(c_ras),
    .sd_cas_(c_cas), .sd_we_(c_we), .sd_ba(c_ba), .sd_adrs(c_adrs),
    .sd_dqm_l(c_dqm), .rd_valid(c_rdv), .init_done(c_init)
  );

  logic [3:0]  o_cmd;
  logic [2:0]  o_ba;
  logic [12:0] o_adrs;
  logic [7:0]  o_dqm;
  logic        o_ready, o_rdv, o_init;

  always_comb begin
    if (sel == 0) begin
      o_cmd   = {a_cs, a_ras, a_cas, a_we};
      o_ba    = {1'b0, a_ba};
      o_adrs  = {1'b0, a_adrs};
      o_dqm   = a_dqm;
      o_ready = a_ready;
      o_rdv   = a_rdv;
      o_init  = a_init;
    end else begin
      o_cmd   = {c_cs, c_ras, c_cas, c_we};
      o_ba    = c_ba;
      o_adrs  = c_adrs;
      o_dqm   = {4'h0, c_dqm};
      o_ready = c_ready;
      o_rdv   = c_rdv;
      o_init  = c_init;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_rst(input logic v);
    if (sel == 0) rst_a = v;
    else          rst_c = v;
  endtask

  function automatic logic [7:0] dqm_ones();
    return (sel == 0) ? 8'hFF : 8'h0F;
  endfunction

  function automatic logic [3:0] exp_init_cmd(input int n);
    case (n)
      11:      return CMD_PRE;
      14, 19:  return CMD_REF;
      24:      return CMD_MRS;
      default: return CMD_NOP;
    endcase
  endfunction

  // Holds reset, checks reset pins, releases and follows the 27-cycle init sequence.
  task automatic run_init();
    set_rst(1'b0);
    tick();
    tick();
    check("rst_cmd", o_cmd, CMD_DESEL);
    check("rst_dqm", o_dqm, dqm_ones());
    check("rst_ready", o_ready, 1'b0);
    check("rst_init_done", o_init, 1'b0);
    check("rst_rd_valid", o_rdv, 1'b0);
    set_rst(1'b1);
    cyc = 0;
    for (int n = 1; n <= 27; n++) begin
      tick();
      check($sformatf("init_cmd[%0d]", n), o_cmd, exp_init_cmd(n));
      check($sformatf("init_dqm[%0d]", n), o_dqm, dqm_ones());
      if (n == 11) check("init_pre_a10", o_adrs[10], 1'b1);
      if (n == 24) begin
        check("init_mrs_adrs", o_adrs, 13'h022);
        check("init_mrs_ba", o_ba, 3'd0);
      end
      if (n == 26) check("init_done_early", o_init, 1'b0);
      if (n == 27) begin
        check("init_done", o_init, 1'b1);
        check("init_ready", o_ready, 1'b1);
      end
    end
    $display("txn init dut=%0d done at cycle %0d", sel, cyc);
  endtask

  // One request from an IDLE cycle with ready high through to the cycle ready should return.
  task automatic access(input bit wr, input logic [2:0] ba, input logic [12:0] row,
                        input logic [9:0] col, input logic [7:0] dqm,
                        input logic [12:0] rw_adrs, input int cl, input bit ready_back);
    int k;
    check("acc_ready_pre", o_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_bank  = ba;
    req_row   = row;
    req_col   = col;
    req_dqm   = dqm;
    tick();
    req_valid = 1'b0;
    check("act_cmd", o_cmd, CMD_ACT);
    check("act_ba", o_ba, ba);
    check("act_adrs", o_adrs, row);
    check("act_ready", o_ready, 1'b0);
    tick();
    check("rcd_cmd", o_cmd, CMD_NOP);
    tick();
    k = cyc;
    check("rw_cmd", o_cmd, wr ? CMD_WR : CMD_RD);
    check("rw_ba", o_ba, ba);
    check("rw_adrs", o_adrs, rw_adrs);
    check("rw_dqm", o_dqm, dqm);
    check("rw_ready", o_ready, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("rd_valid[K+%0d]", i), o_rdv, (!wr && i == cl) ? 1'b1 : 1'b0);
      if (i <= 4) begin
        check($sformatf("done_cmd[%0d]", i), o_cmd, CMD_NOP);
        check($sformatf("done_dqm[%0d]", i), o_dqm, dqm_ones());
        check($sformatf("done_ready[%0d]", i), o_ready, 1'b0);
      end else begin
        check("ready_back", o_ready, ready_back);
      end
    end
    $display("txn %s dut=%0d ba=%0h row=%0h col=%0h dqm=%0h rw_at=%0d",
             wr ? "write" : "read", sel, ba, row, col, dqm, k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1);
  end

  initial begin
    sel = 0;
    run_init();
    // Write then read on the CL=2 instance, both inside the first refresh interval.
    access(1'b1, 3'd1, 13'h3A5, 10'h017, 8'hF0, 13'h417, 2, 1'b1);
    access(1'b0, 3'd2, 13'h155, 10'h003, 8'h00, 13'h403, 2, 1'b1);

    // First refresh request is pending from cycle 77; offer a request in exactly that cycle.
    while (cyc < 76) tick();
    check("ref_ready_76", o_ready, 1'b1);
    tick();
    check("ref_ready_77", o_ready, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_bank  = 3'd3;
    req_row   = 13'h0AB;
    req_col   = 10'h055;
    req_dqm   = 8'h0F;
    tick();
    check("coll_ref_cmd", o_cmd, CMD_REF);
    check("coll_ref_ready", o_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("coll_rfc_cmd[%0d]", i), o_cmd, CMD_NOP);
      check($sformatf("coll_rfc_ready[%0d]", i), o_ready, 1'b0);
    end
    tick();
    $display("txn refresh dut=0 collision REF at cycle 78");
    access(1'b0, 3'd3, 13'h0AB, 10'h055, 8'h0F, 13'h455, 2, 1'b1);

    // Access spanning the second expiry at cycle 127: REF must follow straight after.
    while (cyc < 124) tick();
    access(1'b1, 3'd0, 13'hFFF, 10'h3FF, 8'h3C, 13'h7FF, 2, 1'b0);
    tick();
    check("span_ref_cmd", o_cmd, CMD_REF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("span_rfc_cmd[%0d]", i), o_cmd, CMD_NOP);
    end
    tick();
    check("span_ready_back", o_ready, 1'b1);
    $display("txn refresh dut=0 after access REF at cycle 133");

    // Reset between ACT and RD.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_bank  = 3'd1;
    req_row   = 13'h123;
    req_col   = 10'h001;
    req_dqm   = 8'h00;
    tick();
    req_valid = 1'b0;
    check("mid_act_cmd", o_cmd, CMD_ACT);
    set_rst(1'b0);
    #1;
    check("mid_rst_cmd", o_cmd, CMD_DESEL);
    check("mid_rst_dqm", o_dqm, 8'hFF);
    check("mid_rst_ready", o_ready, 1'b0);
    check("mid_rst_init", o_init, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_rst_hold_cmd[%0d]", i), o_cmd, CMD_DESEL);
      check($sformatf("mid_rst_rdv[%0d]", i), o_rdv, 1'b0);
    end
    $display("txn reset dut=0 mid-access");
    run_init();

    // Wide-address, narrow-mask, CL=3 instance.
    sel = 1;
    run_init();
    access(1'b0, 3'd5, 13'h1ABC, 10'h1FF, 8'h05, 13'h05FF, 3, 1'b1);
    access(1'b1, 3'd2, 13'h0001, 10'h000, 8'h0A, 13'h0400, 3, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
